hamming74_serial_encoder: RTL and testbench

- Serial Hamming(7,4) encoder that sits directly upstream of the team's serial (7,4) decoder.
- Accepts a bit stream of information bits through a valid/ready handshake and groups them into 4-bit nibbles.
- Emits each resulting 7-bit codeword one bit per cycle on data_out, qualified by out_flag, in the order the decoder samples its data_in.
- A one-deep holding register decouples nibble collection from serialization.

---
 rtl/hamming74_serial_encoder_if.sv | 44 ++++
 rtl/hamming74_serial_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_hamming74_serial_encoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming74_serial_encoder_if.sv
// ----------------------------------------------------------------------------
// hamming74_serial_encoder_if
//
// Purpose : bundles the bit-stream handshake and the serial codeword output
//           of the Hamming(7,4) serial encoder.
//
// Signals :
//   data_in   information bit (d0 first, d3 last within a nibble)
//   in_valid  data_in is valid this cycle
//   in_ready  encoder accepts data_in this cycle
//   data_out  serial codeword bit
//   out_flag  data_out carries a codeword bit
//   out_sof   high together with codeword bit c0 only
//
// Modports:
//   master  source side (drives data_in/in_valid, observes the rest)
//   slave   encoder side
// ----------------------------------------------------------------------------
interface hamming74_serial_encoder_if;
    logic data_in;
    logic in_valid;
    logic in_ready;
    logic data_out;
    logic out_flag;
    logic out_sof;

    modport master (
        output data_in,
        output in_valid,
        input  in_ready,
        input  data_out,
        input  out_flag,
        input  out_sof
    );

    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready,
        output data_out,
        output out_flag,
        output out_sof
    );
endinterface

// File: rtl/hamming74_serial_encoder.sv
// ----------------------------------------------------------------------------
// hamming74_serial_encoder
//
// Purpose : collects a serial stream of information bits into nibbles,
//           encodes each nibble as a Hamming(7,4) codeword and sends it out
//           one bit per cycle in the order p1, p2, d0, p3, d1, d2, d3.
//           A one-deep holding register sits between the nibble collector
//           and the serializer so that collection of the next nibble can
//           overlap transmission of the current codeword.
//
// Parameters:
//   GAP            idle cycles (out_flag=0) after each codeword, 0..15
//   INVERT_PARITY  1 inverts p1/p2/p3 (odd parity)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   io    slave modport of hamming74_serial_encoder_if
//         (data_in/in_valid/in_ready in, data_out/out_flag/out_sof out)
// ----------------------------------------------------------------------------
module hamming74_serial_encoder #(
    parameter int GAP           = 0,
    parameter bit INVERT_PARITY = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    hamming74_serial_encoder_if.slave     io
);

    // Last value of the gap counter before the serializer may reload.
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAPW = 2'd2
    } state_t;

    // Collector / holding register
    logic [1:0] r_cnt_in;
    logic [2:0] r_nib;
    logic [6:0] r_hold;
    logic       r_hold_full;

    // Serializer
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] r_gap_cnt;
    logic [3:0] w_gap_cnt_nxt;
    logic [6:0] r_shift;
    logic [6:0] w_shift_nxt;
    logic       r_data_out;
    logic       w_data_out_nxt;
    logic       r_out_flag;
    logic       w_out_flag_nxt;
    logic       r_out_sof;
    logic       w_out_sof_nxt;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_last_bit;
    logic       w_try_load;
    logic       w_load;

    // Codeword bit i is transmitted in cycle i: {d3, d2, d1, p3, d0, p2, p1}.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p3;
        p1 = d[0] ^ d[1] ^ d[3] ^ INVERT_PARITY;
        p2 = d[0] ^ d[2] ^ d[3] ^ INVERT_PARITY;
        p3 = d[1] ^ d[2] ^ d[3] ^ INVERT_PARITY;
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // The 4th bit of a nibble is only taken when the holding register is
    // free, so hold_full can never be set and cleared on the same edge.
    assign w_in_ready = (r_cnt_in != 2'd3) || !r_hold_full;
    assign w_accept   = io.in_valid && w_in_ready;
    assign w_last_bit = (r_cnt_in == 2'd3);

    // ---- collector: control state --------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_in    <= 2'd0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt_in <= w_last_bit ? 2'd0 : r_cnt_in + 2'd1;
            end
            if (w_accept && w_last_bit) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // ---- collector: data path (reset not needed, qualified by control) --
    // Bits enter at the top of r_nib and move down, so after three bits
    // r_nib = {d2, d1, d0} and the 4th bit completes {d3, d2, d1, d0}.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (w_last_bit) begin
                r_hold <= encode({io.data_in, r_nib});
            end else begin
                r_nib <= {io.data_in, r_nib[2:1]};
            end
        end
    end

    // ---- serializer: next-state and output logic -----------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_shift_nxt    = r_shift;
        w_data_out_nxt = 1'b0;
        w_out_flag_nxt = 1'b0;
        w_out_sof_nxt  = 1'b0;
        w_try_load     = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_try_load = 1'b1;
            end

            S_SEND: begin
                if (r_bit_cnt != 3'd6) begin
                    // r_shift[0] is on data_out now; present the next bit.
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    w_shift_nxt    = {1'b0, r_shift[6:1]};
                    w_data_out_nxt = r_shift[1];
                    w_out_flag_nxt = 1'b1;
                end else if (GAP > 0) begin
                    w_state_nxt   = S_GAPW;
                    w_gap_cnt_nxt = 4'd0;
                end else begin
                    // Back-to-back: c0 of the next codeword follows c6.
                    w_try_load = 1'b1;
                end
            end

            S_GAPW: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_try_load = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_try_load) begin
            if (r_hold_full) begin
                w_load         = 1'b1;
                w_state_nxt    = S_SEND;
                w_bit_cnt_nxt  = 3'd0;
                w_shift_nxt    = r_hold;
                w_data_out_nxt = r_hold[0];
                w_out_flag_nxt = 1'b1;
                w_out_sof_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // ---- serializer: state and registered outputs ----------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_gap_cnt  <= 4'd0;
            r_data_out <= 1'b0;
            r_out_flag <= 1'b0;
            r_out_sof  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_data_out <= w_data_out_nxt;
            r_out_flag <= w_out_flag_nxt;
            r_out_sof  <= w_out_sof_nxt;
        end
    end

    // ---- serializer: shift register (data only) ------------------------
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign io.in_ready = w_in_ready;
    assign io.data_out = r_data_out;
    assign io.out_flag = r_out_flag;
    assign io.out_sof  = r_out_sof;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// ----------------------------------------------------------------------------
// tb_hamming74_serial_encoder
//
// Two encoder instances: dut0 (GAP=0, even parity) and dut1 (GAP=3, odd
// parity). Drivers push expected codeword bits into per-instance queues as
// nibbles complete; a monitor on the falling edge pops and compares every
// bit the encoders present.
// ----------------------------------------------------------------------------
module tb_hamming74_serial_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming74_serial_encoder_if if0();
    hamming74_serial_encoder_if if1();

    hamming74_serial_encoder #(.GAP(0), .INVERT_PARITY(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .io  (if0)
    );

    hamming74_serial_encoder #(.GAP(3), .INVERT_PARITY(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .io  (if1)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] q0[$];          // expected {sof, bit} for dut0
    logic [1:0] q1[$];          // expected {sof, bit} for dut1
    logic [3:0] nib_v [2];
    int         nib_c [2];
    logic [6:0] lit_cw [2];
    bit         lit_en [2];
    int         stalls [2];
    bit         mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: classic Hamming positions 1..7; parity bits sit at powers
    // of two, data fills the rest in order, parity at position p covers all
    // positions whose index has bit p set. Position n is transmitted n-th.
    function automatic logic [6:0] ref_cw(logic [3:0] d, bit inv);
        logic       c [8];
        logic [6:0] r;
        logic       x;
        int         di;
        di = 0;
        for (int pos = 0; pos < 8; pos++) c[pos] = 1'b0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            int p;
            p = 1 << k;
            x = inv;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & p) != 0) && (pos != p)) x = x ^ c[pos];
            c[p] = x;
        end
        for (int pos = 1; pos <= 7; pos++) r[pos-1] = c[pos];
        return r;
    endfunction

    function automatic logic get_flag(int sel);
        return (sel == 0) ? if0.out_flag : if1.out_flag;
    endfunction
    function automatic logic get_sof(int sel);
        return (sel == 0) ? if0.out_sof : if1.out_sof;
    endfunction
    function automatic logic get_dout(int sel);
        return (sel == 0) ? if0.data_out : if1.data_out;
    endfunction
    function automatic logic get_ready(int sel);
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    task automatic set_in(int sel, logic v, logic b);
        if (sel == 0) begin
            if0.in_valid = v;
            if0.data_in  = b;
        end else begin
            if1.in_valid = v;
            if1.data_in  = b;
        end
    endtask

    task automatic push_cw(int sel, logic [6:0] cw);
        logic [1:0] e;
        for (int i = 0; i < 7; i++) begin
            e = {(i == 0), cw[i]};
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic model_accept(int sel, logic b);
        logic [6:0] cw;
        nib_v[sel][nib_c[sel]] = b;
        nib_c[sel]++;
        if (nib_c[sel] == 4) begin
            cw = lit_en[sel] ? lit_cw[sel] : ref_cw(nib_v[sel], sel == 1);
            lit_en[sel] = 1'b0;
            nib_c[sel]  = 0;
            push_cw(sel, cw);
        end
    endtask

    // Holds in_valid high until the bit is taken (bounded).
    task automatic put_bit(int sel, logic b);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            set_in(sel, 1'b1, b);
            acc = get_ready(sel);
            if (!acc) stalls[sel]++;
            @(posedge clk);
            if (acc) model_accept(sel, b);
            tries++;
        end
        if (!acc) chk($sformatf("dut%0d_accept_timeout", sel), 0, 1);
    endtask

    task automatic put_nib(int sel, logic [3:0] d, bit use_lit, logic [6:0] lit);
        lit_en[sel] = use_lit;
        lit_cw[sel] = lit;
        for (int i = 0; i < 4; i++) put_bit(sel, d[i]);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            set_in(0, 1'b0, 1'b0);
            set_in(1, 1'b0, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic idle_one(int sel);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0);
        @(posedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        idle(8);
        chk("drain_q0_empty", q0.size(), 0);
        chk("drain_q1_empty", q1.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        @(posedge clk);
        q0.delete();
        q1.delete();
        nib_c[0] = 0;
        nib_c[1] = 0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d_rst_flag", k),  get_flag(k),  0);
            chk($sformatf("dut%0d_rst_dout", k),  get_dout(k),  0);
            chk($sformatf("dut%0d_rst_sof", k),   get_sof(k),   0);
            chk($sformatf("dut%0d_rst_ready", k), get_ready(k), 1);
        end
        rst = 1'b0;
    endtask

    // Waits for a start of frame, then measures the out_flag high run and
    // the following low run (each bounded).
    task automatic meas_run(int sel, int max_gap, output int run, output int gap,
                            output logic sof_after);
        int t;
        t = 0; run = 0; gap = 0;
        @(negedge clk);
        while (!get_sof(sel) && t < 200) begin
            @(negedge clk);
            t++;
        end
        while (get_flag(sel) && run < 200) begin
            run++;
            @(negedge clk);
        end
        while (!get_flag(sel) && gap < max_gap) begin
            gap++;
            @(negedge clk);
        end
        sof_after = get_sof(sel);
    endtask

    // ---- scoreboard monitor --------------------------------------------
    logic       mon_f, mon_d, mon_s, mon_empty;
    logic [1:0] mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                mon_f = get_flag(k);
                mon_d = get_dout(k);
                mon_s = get_sof(k);
                if (mon_f) begin
                    mon_empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (mon_empty) begin
                        chk($sformatf("dut%0d_unexpected_bit", k), 1, 0);
                    end else begin
                        if (k == 0) mon_e = q0.pop_front();
                        else        mon_e = q1.pop_front();
                        chk($sformatf("dut%0d_data_out", k), mon_d, mon_e[0]);
                        chk($sformatf("dut%0d_out_sof", k),  mon_s, mon_e[1]);
                    end
                end else begin
                    chk($sformatf("dut%0d_idle_dout", k), mon_d, 0);
                    chk($sformatf("dut%0d_idle_sof", k),  mon_s, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---- stimulus ------------------------------------------------------
    int   run0, gap0, run1, gap1;
    logic sof0, sof1;
    logic [3:0] rnib;

    initial begin
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            nib_c[k] = 0; lit_en[k] = 1'b0; stalls[k] = 0; nib_v[k] = '0; lit_cw[k] = '0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        // Nibble 0000 and its latency: c0 two edges after d3 is sampled.
        put_nib(0, 4'b0000, 1'b1, 7'b0000000);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        chk("lat_after_edge1_flag", get_flag(0), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_after_edge2_flag", get_flag(0), 1);
        chk("lat_after_edge2_sof",  get_sof(0),  1);
        drain();

        // Known codewords (d0 is bit 0 of the nibble argument).
        put_nib(0, 4'b1011, 1'b1, 7'b1010101);
        drain();
        put_nib(0, 4'b0001, 1'b1, 7'b0000111);
        drain();
        put_nib(0, 4'b1111, 1'b1, 7'b1111111);
        drain();
        put_nib(1, 4'b0000, 1'b1, 7'b0001011);
        drain();

        // Continuous in_valid over 24 bits, GAP=0.
        stalls[0] = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) put_bit(0, 1'($urandom));
                idle_one(0);
            end
            meas_run(0, 20, run0, gap0, sof0);
        join
        chk("cont_flag_run", run0, 42);
        chk("cont_ready_stalled", (stalls[0] > 0), 1);
        drain();

        // GAP=3, two nibbles back-to-back.
        fork
            begin
                for (int i = 0; i < 8; i++) put_bit(1, 1'($urandom));
                idle_one(1);
            end
            meas_run(1, 50, run1, gap1, sof1);
        join
        chk("gap_first_run", run1, 7);
        chk("gap_length", gap1, 3);
        chk("gap_next_sof", sof1, 1);
        drain();

        // Reset at c3 of a codeword with two bits of the next nibble held.
        rnib = 4'($urandom);
        put_nib(0, rnib, 1'b0, 7'b0);
        put_bit(0, 1'($urandom));
        put_bit(0, 1'($urandom));
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_at_c3_flag", get_flag(0), 1);
        rst = 1'b1;
        set_in(0, 1'b1, 1'b1);
        @(posedge clk);
        q0.delete();
        q1.delete();
        nib_c[0] = 0;
        nib_c[1] = 0;
        @(negedge clk);
        chk("rst_mid_flag",  get_flag(0),  0);
        chk("rst_mid_dout",  get_dout(0),  0);
        chk("rst_mid_sof",   get_sof(0),   0);
        chk("rst_mid_ready", get_ready(0), 1);
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0);
        put_nib(0, 4'($urandom), 1'b0, 7'b0);
        drain();

        // Randomized traffic on both instances with random idle cycles.
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    if ($urandom_range(0, 3) == 0) idle_one(0);
                    put_bit(0, 1'($urandom));
                end
                idle_one(0);
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 2) == 0) idle_one(1);
                    put_bit(1, 1'($urandom));
                end
                idle_one(1);
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
